run_len_detector: RTL and testbench
===================================

RUN_LEN_DETECTOR -- requirements
Module: run_len_detector

Interface
REQ-001 SHALL have parameter RUN_LEN, default 3, meaning the run length to detect (legal 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the detection-counter width (legal 1..32).
REQ-003 SHALL use one clock, clk; reset is synchronous and active-high, rst.
REQ-004 SHALL provide the following ports:
- clk  input  1  clock, all state updates on the rising edge
- rst  input  1  synchronous active-high reset
- x  input  1  serial data bit
- in_valid  input  1  x is sampled only when high
- mode  input  2  00 = detect runs of ones; 01 = runs of zeros; 10 = either; 11 = detection disabled
- overlap  input  1  1 = overlapping detection; 0 = non-overlapping
- clr_cnt  input  1  synchronous clear of det_cnt
- y  output  1  Mealy detect pulse
- y_val  output  1  value of the detected run (meaningful only while y = 1)
- run_cnt  output  $clog2(RUN_LEN+1)  current registered run length
- det_cnt  output  CNT_W  saturating count of y pulses

Function
REQ-005 SHALL implement an FSM with states IDLE (no history), RUN0 (last accepted bit 0) and RUN1 (last accepted bit 1).
REQ-006 On an accepted sample (in_valid = 1): from IDLE, or when x differs from the last bit, the next run length SHALL be 1; otherwise the next run length SHALL be run_cnt + 1.
REQ-007 y SHALL be combinational (Mealy) and equal in_valid & (next run length == RUN_LEN) & mode_match, where mode_match is: mode 00 and x = 1; mode 01 and x = 0; mode 10 always; mode 11 never.
REQ-008 y_val SHALL equal x combinationally; it is meaningful only while y = 1.
REQ-009 When y = 1 and overlap = 1, run_cnt SHALL register RUN_LEN-1 and the state SHALL become RUN1 or RUN0 according to x, so that each further identical bit fires again.
REQ-010 When y = 1 and overlap = 0, run_cnt SHALL register 0 and the state SHALL become IDLE, so that the next bit starts a fresh run.
REQ-011 A run that reaches RUN_LEN without a detection (blocked by mode) SHALL saturate run_cnt at RUN_LEN-1 and remain in RUN0/RUN1.
REQ-012 When in_valid = 0, state, run_cnt and det_cnt SHALL hold and y SHALL be 0, independent of x.
REQ-013 Changes to mode and overlap SHALL take effect on the same cycle's sample; run counting SHALL be independent of mode.
REQ-014 det_cnt SHALL increment on each cycle with y = 1 and SHALL saturate at 2^CNT_W-1.
REQ-015 When clr_cnt = 1, det_cnt SHALL register 0; clr_cnt SHALL win over a simultaneous y. y itself SHALL be unaffected by clr_cnt.

Reset
REQ-016 While rst = 1, at the clock edge the state SHALL become IDLE, run_cnt 0 and det_cnt 0; rst SHALL take priority over all other inputs.
REQ-017 y SHALL be forced to 0 while rst = 1.
REQ-018 Reset asserted mid-run SHALL discard run history; the first valid sample after reset SHALL count as run length 1.

Structure
REQ-019 State encoding (IDLE/RUN0/RUN1) and mode encodings SHALL live in the shared package seq_det_pkg.
REQ-020 The saturating, clearable counter SHALL be the sub-module sat_counter (parameter CNT_W); the FSM and run counter SHALL stay in run_len_detector.

Verification (RUN_LEN = 3, CNT_W = 8 unless stated)
REQ-021 Overlapping zeros: mode = 10, overlap = 1, x = 000000 on consecutive valid cycles -> y on samples 3, 4, 5 and 6, y_val = 0, det_cnt = 4.
REQ-022 Non-overlapping ones: mode = 10, overlap = 0, x = 1111111 -> y on samples 3 and 6 only, det_cnt = 2.
REQ-023 Mode filter: mode = 00, overlap = 1, x = 000111 -> y only on sample 6 with y_val = 1; mode = 11 with the same input -> no y.
REQ-024 Valid gaps and reset: x = 1,1 (valid); then in_valid = 0 for 3 cycles with x toggling; then x = 1 (valid) -> y on that sample. Repeat with rst pulsed during the gap -> no y until 3 fresh ones.
REQ-025 Counter: CNT_W = 2, overlap = 1, mode = 10, ten consecutive ones -> det_cnt saturates at 3. Then clr_cnt asserted together with a y pulse -> det_cnt = 0, and y is still 1 that cycle.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg
//   Shared encodings for the run-length detector: FSM state names, the
//   detection-mode field, and a helper that decides whether a completed run
//   of value x is reportable under a given mode.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN0 = 2'b01,
    ST_RUN1 = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    MODE_ONES   = 2'b00,
    MODE_ZEROS  = 2'b01,
    MODE_EITHER = 2'b10,
    MODE_OFF    = 2'b11
  } mode_e;

  function automatic logic mode_match(input mode_e mode, input logic x);
    logic m;
    case (mode)
      MODE_ONES:   m = x;
      MODE_ZEROS:  m = ~x;
      MODE_EITHER: m = 1'b1;
      default:     m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset (highest priority)
//     clr  - synchronous clear, wins over inc
//     inc  - count one event this cycle
//     cnt  - current count, holds at all-ones
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/run_len_detector.sv
// run_len_detector
//   Detects runs of RUN_LEN identical accepted bits on a serial stream and
//   reports them with a Mealy pulse; counts pulses in a saturating counter.
//   Ports:
//     clk, rst  - clock and synchronous active-high reset
//     x         - serial data bit, accepted when in_valid = 1
//     mode      - 00 ones, 01 zeros, 10 either, 11 disabled
//     overlap   - 1 keeps the run alive after a detection, 0 restarts it
//     clr_cnt   - synchronous clear of det_cnt
//     y, y_val  - detect pulse and the value of the detected run
//     run_cnt   - registered run length
//     det_cnt   - saturating count of y pulses
//
//   state   | meaning
//   --------+-------------------------------
//   ST_IDLE | no history, next bit starts a run
//   ST_RUN0 | last accepted bit was 0
//   ST_RUN1 | last accepted bit was 1
module run_len_detector
  import seq_det_pkg::*;
#(
  parameter int RUN_LEN = 3,
  parameter int CNT_W   = 8,
  localparam int RC_W   = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             y,
  output logic             y_val,
  output logic [RC_W-1:0]  run_cnt,
  output logic [CNT_W-1:0] det_cnt
);

  localparam logic [RC_W-1:0] RUN_LEN_C = RC_W'(RUN_LEN);
  localparam logic [RC_W-1:0] ONE_C     = RC_W'(1);

  state_e          state_q, state_d;
  logic [RC_W-1:0] run_cnt_q, run_cnt_d;
  logic [RC_W-1:0] next_len;
  logic            same_bit;
  logic            hit;

  always_comb begin
    same_bit = ((state_q == ST_RUN1) && x) || ((state_q == ST_RUN0) && !x);
    next_len = same_bit ? (run_cnt_q + ONE_C) : ONE_C;
    hit      = (next_len == RUN_LEN_C);
    y        = !rst && in_valid && hit && mode_match(mode_e'(mode), x);

    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    if (in_valid) begin
      if (y && !overlap) begin
        state_d   = ST_IDLE;
        run_cnt_d = '0;
      end else begin
        state_d   = x ? ST_RUN1 : ST_RUN0;
        // A full run parks one short of RUN_LEN so every further identical
        // bit completes the run again, whether or not it was reported.
        run_cnt_d = hit ? (RUN_LEN_C - ONE_C) : next_len;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      run_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  assign y_val   = x;
  assign run_cnt = run_cnt_q;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_det_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (y),
    .cnt (det_cnt)
  );

endmodule

// File: tb/tb_run_len_detector.sv
module tb_run_len_detector;

  logic       clk = 1'b0;
  logic       rst, x, in_valid, overlap, clr_cnt;
  logic [1:0] mode;

  logic       y, y_val, y2, y_val2;
  logic [1:0] run_cnt, run_cnt2;
  logic [7:0] det_cnt;
  logic [1:0] det_cnt2;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  run_len_detector #(.RUN_LEN(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .mode(mode),
    .overlap(overlap), .clr_cnt(clr_cnt), .y(y), .y_val(y_val),
    .run_cnt(run_cnt), .det_cnt(det_cnt)
  );

  run_len_detector #(.RUN_LEN(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .mode(mode),
    .overlap(overlap), .clr_cnt(clr_cnt), .y(y2), .y_val(y_val2),
    .run_cnt(run_cnt2), .det_cnt(det_cnt2)
  );

  typedef struct {
    logic       r, v, xx;
    logic [1:0] m;
    logic       ov, c, ey;
    int         erc, edc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic add(input logic r, v, xx, input logic [1:0] m,
                     input logic ov, c, ey, input int erc, edc);
    vec_t e;
    e.r = r; e.v = v; e.xx = xx; e.m = m; e.ov = ov; e.c = c;
    e.ey = ey; e.erc = erc; e.edc = edc;
    vecs.push_back(e);
  endtask

  // Inputs change 1 time unit after the rising edge; combinational outputs
  // are sampled 3 units later, registered outputs 1 unit after the next edge.
  task automatic drive(input logic r, v, xx, input logic [1:0] m, input logic ov, c);
    rst = r; in_valid = v; x = xx; mode = m; overlap = ov; clr_cnt = c;
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model state (unbounded run length)
  int m_len, m_det8, m_det2;
  bit m_have, m_val;

  initial begin
    rst = 1'b1; x = 1'b0; in_valid = 1'b0; mode = 2'b10; overlap = 1'b0; clr_cnt = 1'b0;
    tick();

    // reset
    add(1,0,0,2'b10,1,0, 0,0,0);
    // overlapping zeros, mode either
    add(0,1,0,2'b10,1,0, 0,1,0);
    add(0,1,0,2'b10,1,0, 0,2,0);
    add(0,1,0,2'b10,1,0, 1,2,1);
    add(0,1,0,2'b10,1,0, 1,2,2);
    add(0,1,0,2'b10,1,0, 1,2,3);
    add(0,1,0,2'b10,1,0, 1,2,4);
    add(1,0,0,2'b10,0,0, 0,0,0);
    // non-overlapping ones
    add(0,1,1,2'b10,0,0, 0,1,0);
    add(0,1,1,2'b10,0,0, 0,2,0);
    add(0,1,1,2'b10,0,0, 1,0,1);
    add(0,1,1,2'b10,0,0, 0,1,1);
    add(0,1,1,2'b10,0,0, 0,2,1);
    add(0,1,1,2'b10,0,0, 1,0,2);
    add(0,1,1,2'b10,0,0, 0,1,2);
    add(1,0,0,2'b00,1,0, 0,0,0);
    // mode ones filters a run of zeros, which saturates run_cnt
    add(0,1,0,2'b00,1,0, 0,1,0);
    add(0,1,0,2'b00,1,0, 0,2,0);
    add(0,1,0,2'b00,1,0, 0,2,0);
    add(0,1,1,2'b00,1,0, 0,1,0);
    add(0,1,1,2'b00,1,0, 0,2,0);
    add(0,1,1,2'b00,1,0, 1,2,1);
    add(1,0,0,2'b11,1,0, 0,0,0);
    // mode disabled
    add(0,1,0,2'b11,1,0, 0,1,0);
    add(0,1,0,2'b11,1,0, 0,2,0);
    add(0,1,0,2'b11,1,0, 0,2,0);
    add(0,1,1,2'b11,1,0, 0,1,0);
    add(0,1,1,2'b11,1,0, 0,2,0);
    add(0,1,1,2'b11,1,0, 0,2,0);
    add(1,0,0,2'b10,1,0, 0,0,0);
    // valid gap holds history
    add(0,1,1,2'b10,1,0, 0,1,0);
    add(0,1,1,2'b10,1,0, 0,2,0);
    add(0,0,0,2'b10,1,0, 0,2,0);
    add(0,0,1,2'b10,1,0, 0,2,0);
    add(0,0,0,2'b10,1,0, 0,2,0);
    add(0,1,1,2'b10,1,0, 1,2,1);
    add(1,0,0,2'b10,1,0, 0,0,0);
    // reset inside the gap discards history
    add(0,1,1,2'b10,1,0, 0,1,0);
    add(0,1,1,2'b10,1,0, 0,2,0);
    add(0,0,0,2'b10,1,0, 0,2,0);
    add(1,0,1,2'b10,1,0, 0,0,0);
    add(0,0,0,2'b10,1,0, 0,0,0);
    add(0,1,1,2'b10,1,0, 0,1,0);
    add(0,1,1,2'b10,1,0, 0,2,0);
    add(0,1,1,2'b10,1,0, 1,2,1);
    // reset blocks a would-be detection
    add(1,1,1,2'b10,1,0, 0,0,0);
    // clear wins over a simultaneous detection
    add(0,1,1,2'b10,1,0, 0,1,0);
    add(0,1,1,2'b10,1,0, 0,2,0);
    add(0,1,1,2'b10,1,0, 1,2,1);
    add(0,1,1,2'b10,1,1, 1,2,0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].v, vecs[i].xx, vecs[i].m, vecs[i].ov, vecs[i].c);
      chk($sformatf("vec%0d_y", i), int'(y), int'(vecs[i].ey));
      if (vecs[i].ey) chk($sformatf("vec%0d_y_val", i), int'(y_val), int'(vecs[i].xx));
      tick();
      chk($sformatf("vec%0d_run_cnt", i), int'(run_cnt), vecs[i].erc);
      chk($sformatf("vec%0d_det_cnt", i), int'(det_cnt), vecs[i].edc);
    end

    // narrow counter saturation, then clear together with a pulse
    drive(1,0,0,2'b10,1,0);
    tick();
    for (int k = 1; k <= 10; k++) begin
      int exp_d;
      drive(0,1,1,2'b10,1,0);
      chk($sformatf("sat_k%0d_y2", k), int'(y2), (k >= 3) ? 1 : 0);
      tick();
      exp_d = (k >= 3) ? k - 2 : 0;
      if (exp_d > 3) exp_d = 3;
      chk($sformatf("sat_k%0d_det2", k), int'(det_cnt2), exp_d);
    end
    chk("sat_det8", int'(det_cnt), 8);
    drive(0,1,1,2'b10,1,1);
    chk("clr_y2", int'(y2), 1);
    tick();
    chk("clr_det2", int'(det_cnt2), 0);
    chk("clr_det8", int'(det_cnt), 0);

    // randomized run against the reference model
    m_len = 0; m_have = 0; m_val = 0; m_det8 = 0; m_det2 = 0;
    begin
      logic       r, v, xx, ov, c, prev_x;
      logic [1:0] m;
      bit         ey, mm;
      int         nlen, erc;
      prev_x = 1'b0;
      for (int n = 0; n < 600; n++) begin
        r  = (n == 0) || ($urandom_range(0, 59) == 0);
        v  = ($urandom_range(0, 3) != 0);
        xx = ($urandom_range(0, 9) < 7) ? prev_x : ~prev_x;
        prev_x = xx;
        m  = 2'($urandom_range(0, 3));
        ov = 1'($urandom_range(0, 1));
        c  = ($urandom_range(0, 39) == 0);

        ey = 0; nlen = 0;
        if (!r && v) begin
          nlen = (m_have && (xx == m_val)) ? m_len + 1 : 1;
          case (m)
            2'b00:   mm = xx;
            2'b01:   mm = !xx;
            2'b10:   mm = 1;
            default: mm = 0;
          endcase
          ey = (nlen >= 3) && mm;
        end

        drive(r, v, xx, m, ov, c);
        chk($sformatf("rnd%0d_y", n), int'(y), int'(ey));
        chk($sformatf("rnd%0d_y2", n), int'(y2), int'(ey));
        if (ey) chk($sformatf("rnd%0d_y_val", n), int'(y_val), int'(xx));
        tick();

        if (r) begin
          m_have = 0; m_len = 0; m_det8 = 0; m_det2 = 0;
        end else begin
          if (v) begin
            if (ey && !ov) begin
              m_have = 0; m_len = 0;
            end else begin
              m_have = 1; m_val = xx; m_len = nlen;
            end
          end
          if (c) begin
            m_det8 = 0; m_det2 = 0;
          end else if (ey) begin
            if (m_det8 < 255) m_det8++;
            if (m_det2 < 3) m_det2++;
          end
        end
        erc = m_have ? ((m_len > 2) ? 2 : m_len) : 0;
        chk($sformatf("rnd%0d_run_cnt", n), int'(run_cnt), erc);
        chk($sformatf("rnd%0d_run_cnt2", n), int'(run_cnt2), erc);
        chk($sformatf("rnd%0d_det_cnt", n), int'(det_cnt), m_det8);
        chk($sformatf("rnd%0d_det_cnt2", n), int'(det_cnt2), m_det2);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
